// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch unit; single-outstanding word fetch feeding the
//            decode stage over a valid/ready handshake, with PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter int                   INS_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic                 o_mem_req,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [INS_WIDTH-1:0] i_mem_rdata,
    output logic [INS_WIDTH-1:0] o_instr,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_misalign
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CPU_WIDTH-1:0]   pc_q;
    logic                   drop_q;
    logic [INS_WIDTH-1:0]   instr_q;
    logic [CPU_WIDTH-1:0]   opc_q;
    logic                   valid_q;
    logic                   misalign_q;

    logic [CPU_WIDTH-1:0]   w_redirect_pc;

    assign w_redirect_pc = {i_redirect_pc[CPU_WIDTH-1:2], 2'b00};

    // Reset gates the request so memory never sees one while the core is held.
    assign o_mem_req    = (state_q == S_REQ) && i_rst_n;
    assign o_mem_addr   = pc_q;
    assign o_instr      = instr_q;
    assign o_pc         = opc_q;
    assign o_post_valid = valid_q;
    assign o_misalign   = misalign_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= '0;
            opc_q      <= RESET_PC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= i_redirect && (|i_redirect_pc[1:0]);
            if (i_redirect) begin
                pc_q    <= w_redirect_pc;
                valid_q <= 1'b0;
                unique case (state_q)
                    S_REQ: begin
                        // A grant in this cycle launches an old-path fetch that must be dropped.
                        if (i_mem_gnt) begin
                            drop_q  <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (i_mem_rvalid) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_REQ;
                    end
                endcase
            end else begin
                unique case (state_q)
                    S_REQ: begin
                        if (i_mem_gnt) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (i_mem_rvalid) begin
                            if (drop_q) begin
                                drop_q  <= 1'b0;
                                state_q <= S_REQ;
                            end else begin
                                instr_q <= i_mem_rdata;
                                opc_q   <= pc_q;
                                valid_q <= 1'b1;
                                state_q <= S_HOLD;
                            end
                        end
                    end
                    default: begin
                        if (i_post_ready) begin
                            pc_q    <= pc_q + CPU_WIDTH'(4);
                            valid_q <= 1'b0;
                            state_q <= S_REQ;
                        end
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Randomized scoreboard bench for ifu_fetch with a memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        i_rst_n;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_post_valid;
    logic        i_post_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_misalign;

    ifu_fetch #(
        .CPU_WIDTH (32),
        .INS_WIDTH (32),
        .RESET_PC  (C_RESET_PC)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_gnt     (i_mem_gnt),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_post_valid  (o_post_valid),
        .i_post_ready  (i_post_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_misalign    (o_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Knobs shared by the directed sequence and the background processes.
    int gnt_pct = 100, lat_min = 1, lat_max = 1, ready_pct = 100, redir_pct = 0;
    bit mem_en = 0, drv_en = 0;
    bit req_redir = 0;
    logic [31:0] redir_tgt = '0;

    // Reference model: the queue holds the PCs the IDU should see, in order.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    bit          mis_exp = 0;
    bit          consume = 0;
    bit          mem_out = 0;
    int          fresh_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_0004) return 32'h0010_0073;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc = C_RESET_PC;
        exp_q.push_back(m_pc);
    endtask

    task automatic chk_reset();
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_mem_addr", o_mem_addr, C_RESET_PC);
        chk("rst_post_valid", 32'(o_post_valid), 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_pc", o_pc, C_RESET_PC);
        chk("rst_misalign", 32'(o_misalign), 32'd0);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_post_valid && n < 60) begin
            run(1);
            n++;
        end
        if (n >= 60) chk(name, 32'(o_post_valid), 32'd1);
    endtask

    task automatic wait_mem_out(input string name);
        int n = 0;
        while (!mem_out && n < 60) begin
            run(1);
            n++;
        end
        if (n >= 60) chk(name, 32'(mem_out), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redir_tgt = t;
        req_redir = 1;
        run(1);
        if (req_redir) begin
            req_redir = 0;
            chk("redirect_issue_timeout", 32'd1, 32'd0);
        end
    endtask

    // Memory responder: grants randomly, returns data after a random latency.
    initial begin : p_mem
        bit          last_gnt = 0, last_req = 0, last_rv = 0;
        logic [31:0] last_addr = '0, addr = '0;
        int          cnt = 0;
        i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                mem_out = 0; i_mem_gnt = 0; i_mem_rvalid = 0;
                last_gnt = 0; last_rv = 0;
            end else if (!mem_en) begin
                mem_out = 0; last_gnt = 0; last_rv = 0;
            end else begin
                if (last_rv) mem_out = 0;
                if (last_gnt && last_req) begin
                    chk("one_outstanding", 32'(mem_out), 32'd0);
                    mem_out = 1;
                    addr    = last_addr;
                    cnt     = $urandom_range(lat_max, lat_min) - 1;
                end
                if (mem_out && cnt == 0) begin
                    i_mem_rvalid = 1;
                    i_mem_rdata  = memf(addr);
                end else begin
                    i_mem_rvalid = 0;
                    i_mem_rdata  = $urandom();
                    if (mem_out) cnt--;
                end
                i_mem_gnt = ($urandom_range(99, 0) < gnt_pct);
                last_gnt  = i_mem_gnt;
                last_req  = o_mem_req;
                last_addr = o_mem_addr;
                last_rv   = i_mem_rvalid;
            end
        end
    end

    // Stimulus driver: issues ready/redirect and advances the reference model.
    initial begin : p_drv
        bit          r, rdy;
        logic [31:0] t;
        i_post_ready = 0; i_redirect = 0; i_redirect_pc = '0;
        forever begin
            @(negedge clk);
            if (!drv_en || !i_rst_n) begin
                i_redirect = 0; i_post_ready = 0; mis_exp = 0; consume = 0;
            end else begin
                r = 0; t = '0;
                if (req_redir) begin
                    r = 1; t = redir_tgt; req_redir = 0;
                end else if ($urandom_range(99, 0) < redir_pct) begin
                    r = 1;
                    case ($urandom_range(3, 0))
                        0: t = $urandom();
                        1: t = 32'h8000_0000 + ($urandom_range(255, 0) * 4) + $urandom_range(3, 0);
                        2: t = 32'hFFFF_FFF0 + $urandom_range(15, 0);
                        default: t = $urandom_range(63, 0);
                    endcase
                end
                rdy = ($urandom_range(99, 0) < ready_pct);
                i_redirect    = r;
                i_redirect_pc = r ? t : $urandom();
                i_post_ready  = rdy;
                consume = o_post_valid && (rdy || r);
                mis_exp = r && (t[1:0] != 2'b00);
                if (r) begin
                    exp_q.delete();
                    m_pc = {t[31:2], 2'b00};
                    exp_q.push_back(m_pc);
                end else if (o_post_valid && rdy) begin
                    m_pc = m_pc + 32'd4;
                    exp_q.push_back(m_pc);
                end
            end
        end
    end

    // Monitor: pops expected PCs on each new presentation and checks hold behaviour.
    initial begin : p_mon
        bit          prev_valid = 0;
        logic [31:0] held_pc = '0, held_instr = '0, e;
        forever begin
            @(posedge clk);
            #1;
            if (!i_rst_n || !drv_en) begin
                prev_valid = 0;
            end else begin
                chk("misalign", 32'(o_misalign), 32'(mis_exp));
                if (o_post_valid) chk("req_while_valid", 32'(o_mem_req), 32'd0);
                if (prev_valid && consume) begin
                    chk("valid_drop_after_take", 32'(o_post_valid), 32'd0);
                end else if (prev_valid) begin
                    chk("hold_valid", 32'(o_post_valid), 32'd1);
                    chk("hold_pc", o_pc, held_pc);
                    chk("hold_instr", o_instr, held_instr);
                end else if (o_post_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output_pc", o_pc, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", o_pc, e);
                        chk("out_instr", o_instr, memf(e));
                    end
                    held_pc    = o_pc;
                    held_instr = o_instr;
                    fresh_cyc.push_back(cyc);
                end
                prev_valid = o_post_valid;
            end
        end
    end

    initial begin : p_main
        int n;
        i_rst_n = 0;
        run(3);
        chk_reset();
        model_reset();
        mem_en = 1; drv_en = 1;
        i_rst_n = 1;
        #1;
        chk("req_after_release", 32'(o_mem_req), 32'd1);

        // Zero-wait memory, ready high: one instruction every three cycles.
        n = 0;
        while (fresh_cyc.size() < 2 && n < 40) begin
            run(1);
            n++;
        end
        if (fresh_cyc.size() < 2) chk("first_two_timeout", 32'(fresh_cyc.size()), 32'd2);
        else chk("throughput_spacing", 32'(fresh_cyc[1] - fresh_cyc[0]), 32'd3);

        // Hold for five cycles with ready low, then release.
        ready_pct = 0;
        wait_valid("hold_wait_timeout");
        run(5);
        ready_pct = 100;
        run(8);

        // Redirect while a slow response is outstanding.
        lat_min = 4; lat_max = 4;
        wait_mem_out("wait_pending_timeout");
        do_redirect(32'h8000_0100);
        run(20);
        lat_min = 1; lat_max = 1;

        // Redirect coincident with ready in the hold state.
        ready_pct = 0;
        wait_valid("hold2_wait_timeout");
        ready_pct = 100;
        do_redirect(32'h8000_0200);
        run(10);

        do_redirect(32'h8000_0102);
        run(10);
        do_redirect(32'hFFFF_FFF8);
        run(20);

        // Randomized traffic.
        gnt_pct = 60; lat_min = 1; lat_max = 4; ready_pct = 60; redir_pct = 4;
        run(3000);

        // Reset while a fetch is outstanding, then a stale rvalid after release.
        redir_pct = 0; gnt_pct = 100; lat_min = 3; lat_max = 3; ready_pct = 100;
        run(4);
        wait_mem_out("wait_pending2_timeout");
        i_rst_n = 0;
        mem_en  = 0;
        #1;
        chk_reset();
        model_reset();
        run(2);
        i_mem_gnt    = 0;
        i_mem_rvalid = 1;
        i_mem_rdata  = 32'hDEAD_BEEF;
        i_rst_n      = 1;
        #1;
        chk("req_after_rst2", 32'(o_mem_req), 32'd1);
        chk("addr_after_rst2", o_mem_addr, C_RESET_PC);
        run(1);
        i_mem_rvalid = 0;
        lat_min = 1; lat_max = 1;
        mem_en = 1;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
